// File: rtl/csa_resolver_pkg.sv
// Shared types and helpers for the carry-save resolver.
package csa_resolver_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    ADD  = 3'b010,
    DONE = 3'b100
  } state_e;

  // Chunk-index width; a single-chunk build still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_resolver_cpa_chunk.sv
// One CHUNK-bit carry-propagate adder slice, purely combinational.
module cpa_chunk #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o
);

  assign {cout_o, s_o} = (CHUNK+1)'(a_i) + (CHUNK+1)'(b_i) + (CHUNK+1)'(cin_i);

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair into a binary word CHUNK bits per cycle.
// Optional: CSA_RESOLVER_EARLY_FINISH_EN stops once all remaining operand bits are zero.
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0] carry_i,
  output logic             finish_valid_o,
  input  logic             finish_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic             zero_o,
  output logic             neg_o
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = idx_width(N);

  if (WIDTH % CHUNK != 0) begin : g_bad_param
    $error("csa_resolver: WIDTH must be a multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cin_q, cin_d;
  logic               zacc_q, zacc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   carry_q, carry_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               rdy_q, rdy_d;
  logic               vld_q, vld_d;

  logic [CHUNK-1:0]   a_c, b_c, s_c;
  logic               cout_c;
  logic               early_c;

  // Operand chunk select for the shared adder slice.
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_c = sum_q[k*CHUNK +: CHUNK];
        b_c = carry_q[k*CHUNK +: CHUNK];
      end
    end
  end

  cpa_chunk #(.CHUNK(CHUNK)) u_cpa (
    .a_i    (a_c),
    .b_i    (b_c),
    .cin_i  (cin_q),
    .s_o    (s_c),
    .cout_o (cout_c)
  );

`ifdef CSA_RESOLVER_EARLY_FINISH_EN
  // upz_c[k]: every operand bit above chunk k is zero.
  logic [N-1:0] upz_c;
  assign upz_c[N-1] = 1'b0;
  for (genvar k = 0; k < N - 1; k++) begin : g_upz
    assign upz_c[k] = ~|{sum_q[WIDTH-1:(k+1)*CHUNK], carry_q[WIDTH-1:(k+1)*CHUNK]};
  end
  assign early_c = ~cout_c & upz_c[idx_q];
`else
  assign early_c = 1'b0;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cin_d   = cin_q;
    zacc_d  = zacc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid_i) begin
          sum_d   = sum_i;
          carry_d = carry_i;
          res_d   = '0;
          idx_d   = '0;
          cin_d   = 1'b0;
          zacc_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int unsigned k = 0; k < N; k++) begin
          if (idx_q == IDX_W'(k)) res_d[k*CHUNK +: CHUNK] = s_c;
        end
        cin_d  = cout_c;
        zacc_d = zacc_q & ~|s_c;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N - 1) || early_c) begin
          zero_d  = zacc_d;
          neg_d   = early_c ? 1'b0 : res_d[WIDTH-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (finish_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
    vld_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cin_q   <= 1'b0;
      zacc_q  <= 1'b1;
      sum_q   <= '0;
      carry_q <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cin_q   <= cin_d;
      zacc_q  <= zacc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign start_ready_o  = rdy_q;
  assign finish_valid_o = vld_q;
  assign res_o          = res_q;
  assign zero_o         = zero_q;
  assign neg_o          = neg_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Randomized and directed checks of csa_resolver against an arithmetic reference model.
module tb_csa_resolver;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned CHUNK = 16;
  localparam int unsigned N     = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             start_valid_i;
  logic             start_ready_o;
  logic [WIDTH-1:0] sum_i;
  logic [WIDTH-1:0] carry_i;
  logic             finish_valid_o;
  logic             finish_ready_i;
  logic [WIDTH-1:0] res_o;
  logic             zero_o;
  logic             neg_o;

  int n_vec;
  int n_err;

  csa_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_valid_i  (start_valid_i),
    .start_ready_o  (start_ready_o),
    .sum_i          (sum_i),
    .carry_i        (carry_i),
    .finish_valid_o (finish_valid_o),
    .finish_ready_i (finish_ready_i),
    .res_o          (res_o),
    .zero_o         (zero_o),
    .neg_o          (neg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycles from accept to result: N, or the first chunk with no carry-out and nothing above it.
  function automatic int exp_lat(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
`ifdef CSA_RESOLVER_EARLY_FINISH_EN
    for (int k = 0; k < int'(N) - 1; k++) begin
      int unsigned w;
      logic [WIDTH:0] mask, low;
      w    = CHUNK * (k + 1);
      mask = (65'd1 << w) - 65'd1;
      low  = ({1'b0, s} & mask) + ({1'b0, c} & mask);
      if ((low >> w) == 0 && (s >> w) == 0 && (c >> w) == 0) return k + 1;
    end
`endif
    return int'(N);
  endfunction

  // Wait for start_ready, launch one operation, check latency and results.
  task automatic launch_and_check(input string tag, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                                  output logic [WIDTH-1:0] exp_res);
    int cyc;
    int budget;
    exp_res = s + c;
    budget  = 0;
    while (!start_ready_o && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk({tag, "_ready"}, 64'(start_ready_o), 64'd1);
    sum_i         = s;
    carry_i       = c;
    start_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid_i = 1'b0;
    sum_i         = {$urandom, $urandom};
    carry_i       = {$urandom, $urandom};
    cyc = 0;
    while (!finish_valid_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid"}, 64'(finish_valid_o), 64'd1);
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat(s, c)));
    chk({tag, "_res"}, res_o, exp_res);
    chk({tag, "_zero"}, 64'(zero_o), 64'(exp_res == '0));
    chk({tag, "_neg"}, 64'(neg_o), 64'(exp_res[WIDTH-1]));
  endtask

  // Complete the finish handshake and confirm return to idle.
  task automatic drain(input string tag);
    finish_ready_i = 1'b1;
    @(negedge clk);
    finish_ready_i = 1'b0;
    chk({tag, "_rdy_after"}, 64'(start_ready_o), 64'd1);
    chk({tag, "_vld_after"}, 64'(finish_valid_o), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] er;
    logic [WIDTH-1:0] rs, rc;
    n_vec          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    start_valid_i  = 1'b0;
    finish_ready_i = 1'b0;
    sum_i          = '0;
    carry_i        = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(start_ready_o), 64'd1);
    chk("rst_valid", 64'(finish_valid_o), 64'd0);
    chk("rst_res", res_o, 64'd0);
    chk("rst_zero", 64'(zero_o), 64'd0);
    chk("rst_neg", 64'(neg_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    launch_and_check("chunk_carry", 64'h0000_0000_0000_FFFF, 64'h1, er);
    drain("chunk_carry");
    launch_and_check("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, er);
    drain("full_ripple");
    launch_and_check("to_neg", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, er);
    drain("to_neg");
    launch_and_check("mid_chunk", 64'h1_0000_0000, 64'h0, er);
    drain("mid_chunk");
    launch_and_check("small", 64'h5, 64'h3, er);

    // Backpressure: result must hold while new starts are ignored.
    for (int i = 0; i < 5; i++) begin
      start_valid_i = 1'b1;
      sum_i         = {$urandom, $urandom};
      carry_i       = {$urandom, $urandom};
      @(negedge clk);
      chk("bp_res", res_o, er);
      chk("bp_ready", 64'(start_ready_o), 64'd0);
      chk("bp_valid", 64'(finish_valid_o), 64'd1);
    end
    start_valid_i = 1'b0;
    drain("bp");

    // Reset during the second ADD cycle, then a clean operation.
    sum_i         = 64'hDEAD_BEEF_0123_4567;
    carry_i       = 64'h1111_2222_3333_4444;
    start_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(finish_valid_o), 64'd0);
    chk("midrst_ready", 64'(start_ready_o), 64'd1);
    chk("midrst_res", res_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch_and_check("post_rst", 64'h2, 64'h2, er);
    drain("post_rst");

    // Randomized operands across full, narrow and all-ones patterns.
    for (int i = 0; i < 40; i++) begin
      int mode;
      int nch;
      mode = int'($urandom_range(0, 3));
      nch  = int'($urandom_range(1, N));
      rs   = {$urandom, $urandom};
      rc   = {$urandom, $urandom};
      case (mode)
        1: begin
          rs = rs & ((nch == int'(N)) ? '1 : ((64'd1 << (CHUNK * nch)) - 64'd1));
          rc = rc & ((nch == int'(N)) ? '1 : ((64'd1 << (CHUNK * nch)) - 64'd1));
        end
        2: begin
          rs = '1;
          rc = 64'(rc[3:0]);
        end
        3: rc = ~rs + 64'(rc[0]);
        default: ;
      endcase
      launch_and_check("rand", rs, rc, er);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rand_hold", res_o, er);
      end
      drain("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
